// File: rtl/pc_seq_pkg.sv
// Shared encodings for the multicycle PC sequencer: FSM states, decoded
// opcode/funct values and PC-source mux select codes.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        JUMP   = 3'd2,
        BRANCH = 3'd3,
        JREG   = 3'd4,
        EXEC   = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] SEL_ALU    = 2'b00;
    localparam logic [1:0] SEL_REG    = 2'b01;
    localparam logic [1:0] SEL_CONCAT = 2'b10;

    // Path taken out of DECODE; the halt opcode is a module parameter.
    function automatic state_t decode_next(input logic [5:0] op,
                                           input logic [5:0] fn,
                                           input logic [5:0] halt_op);
        if (op == OP_J || op == OP_JAL)
            return JUMP;
        else if (op == OP_BEQ || op == OP_BNE)
            return BRANCH;
        else if (op == OP_RTYPE && fn == FN_JR)
            return JREG;
        else if (op == halt_op)
            return HALT;
        else
            return EXEC;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: steps each instruction through FETCH/DECODE and an
// action state, drives the PC-source select, owns the PC and retire counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  OP_HALT  = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic [31:0] next_pc,
    input  logic        imem_valid,
    input  logic        op_done,
    output logic        imem_req,
    output logic [1:0]  sel_pc,
    output logic        pc_write,
    output logic        ir_write,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] retired_reg;
    logic        retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            retired_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (pc_write)
                pc_reg <= next_pc;
            if (retire)
                retired_reg <= retired_reg + 32'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        sel_pc     = SEL_ALU;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        retire     = 1'b0;
        unique case (state_reg)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: state_next = decode_next(opcode, funct, OP_HALT);
            JUMP: begin
                sel_pc     = SEL_CONCAT;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                // Target was latched into ALUOut during DECODE.
                sel_pc     = SEL_REG;
                pc_write   = ((opcode == OP_BEQ) &  alu_zero) |
                             ((opcode == OP_BNE) & ~alu_zero);
                retire     = 1'b1;
                state_next = FETCH;
            end
            JREG: begin
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            EXEC: begin
                if (op_done) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            HALT: state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    assign pc      = pc_reg;
    assign retired = retired_reg;
    assign halted  = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Instruction-level randomized bench for pc_sequencer: each instruction is
// driven phase by phase and outputs are checked against an architectural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        alu_zero;
    logic [31:0] next_pc;
    logic        imem_valid, op_done;
    logic        imem_req, pc_write, ir_write, halted;
    logic [1:0]  sel_pc;
    logic [31:0] pc, retired;

    int checks = 0;
    int errors = 0;

    // Architectural model: the PC and retired count as seen between instructions.
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    pc_sequencer #(.RESET_PC(RESET_PC), .OP_HALT(6'b111111)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .next_pc(next_pc), .imem_valid(imem_valid),
        .op_done(op_done), .imem_req(imem_req), .sel_pc(sel_pc),
        .pc_write(pc_write), .ir_write(ir_write), .pc(pc),
        .retired(retired), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_common();
        check("pc", pc, m_pc);
        check("retired", retired, m_ret);
        check("sel_not_11", {31'd0, sel_pc == 2'b11}, 32'd0);
    endtask

    task automatic randomize_misc();
        next_pc  = $urandom;
        alu_zero = 1'($urandom);
        op_done  = 1'($urandom);
    endtask

    // FETCH phase: 'stall' cycles without a valid word, then the accepting cycle.
    task automatic do_fetch(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            randomize_misc();
            imem_valid = 1'b0;
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            #1;
            check_common();
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_sel", {30'd0, sel_pc}, 32'd0);
            check("stall_pcw", {31'd0, pc_write}, 32'd0);
            check("stall_irw", {31'd0, ir_write}, 32'd0);
            check("stall_halt", {31'd0, halted}, 32'd0);
        end
        @(negedge clk);
        randomize_misc();
        imem_valid = 1'b1;
        next_pc    = m_pc + 32'd4;
        #1;
        check_common();
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_sel", {30'd0, sel_pc}, 32'd0);
        check("fetch_pcw", {31'd0, pc_write}, 32'd1);
        check("fetch_irw", {31'd0, ir_write}, 32'd1);
        m_pc = m_pc + 32'd4;
    endtask

    task automatic do_decode(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        randomize_misc();
        imem_valid = 1'($urandom);
        opcode = op;
        funct  = fn;
        #1;
        check_common();
        check("dec_req", {31'd0, imem_req}, 32'd0);
        check("dec_sel", {30'd0, sel_pc}, 32'd0);
        check("dec_pcw", {31'd0, pc_write}, 32'd0);
        check("dec_irw", {31'd0, ir_write}, 32'd0);
    endtask

    // kind: 0 jump, 1 branch, 2 jr, 3 exec. variant picks J/JAL, BEQ/BNE, add/other.
    task automatic run_instr(input int kind, input int variant, input int stall,
                             input logic [31:0] target, input logic zero, input int wait_cycles);
        logic [5:0] op, fn;
        logic taken;
        fn = 6'($urandom);
        case (kind)
            0: op = (variant != 0) ? 6'b000011 : 6'b000010;
            1: op = (variant != 0) ? 6'b000101 : 6'b000100;
            2: begin op = 6'b000000; fn = 6'b001000; end
            default: begin
                if (variant == 0) begin
                    op = 6'b000000; fn = 6'b100000;
                end else begin
                    do op = 6'($urandom);
                    while (op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd63});
                end
            end
        endcase
        do_fetch(stall);
        do_decode(op, fn);
        if (kind == 3) begin
            for (int i = 0; i <= wait_cycles; i++) begin
                @(negedge clk);
                next_pc    = $urandom;
                alu_zero   = 1'($urandom);
                imem_valid = 1'($urandom);
                op_done    = (i == wait_cycles);
                #1;
                check_common();
                check("exec_req", {31'd0, imem_req}, 32'd0);
                check("exec_sel", {30'd0, sel_pc}, 32'd0);
                check("exec_pcw", {31'd0, pc_write}, 32'd0);
                check("exec_irw", {31'd0, ir_write}, 32'd0);
            end
            m_ret = m_ret + 32'd1;
        end else begin
            @(negedge clk);
            next_pc    = target;
            alu_zero   = zero;
            imem_valid = 1'($urandom);
            op_done    = 1'($urandom);
            #1;
            check_common();
            check("act_req", {31'd0, imem_req}, 32'd0);
            check("act_irw", {31'd0, ir_write}, 32'd0);
            if (kind == 0) begin
                check("jump_sel", {30'd0, sel_pc}, 32'd2);
                check("jump_pcw", {31'd0, pc_write}, 32'd1);
                m_pc = target;
            end else if (kind == 1) begin
                taken = (variant != 0) ? !zero : zero;
                check("br_sel", {30'd0, sel_pc}, 32'd1);
                check("br_pcw", {31'd0, pc_write}, {31'd0, taken});
                if (taken)
                    m_pc = target;
            end else begin
                check("jr_sel", {30'd0, sel_pc}, 32'd0);
                check("jr_pcw", {31'd0, pc_write}, 32'd1);
                m_pc = target;
            end
            m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, RESET_PC);
        check({tag, "_retired"}, retired, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_sel"}, {30'd0, sel_pc}, 32'd0);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_pcw"}, {31'd0, pc_write}, 32'd0);
        check({tag, "_irw"}, {31'd0, ir_write}, 32'd0);
        m_pc  = RESET_PC;
        m_ret = 32'd0;
    endtask

    initial begin
        reset = 1'b1; imem_valid = 1'b0; op_done = 1'b0; alu_zero = 1'b0;
        opcode = 6'd0; funct = 6'd0; next_pc = 32'd0;
        #2;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;

        // Directed: stalled fetch + jump, BEQ taken, BNE not taken, R-type add.
        run_instr(0, 0, 4, 32'h0040_0020, 1'b0, 0);
        run_instr(1, 0, 0, 32'h0000_0040, 1'b1, 0);
        run_instr(1, 1, 0, 32'h0000_0080, 1'b1, 0);
        run_instr(3, 0, 0, 32'h0, 1'b0, 3);
        run_instr(3, 0, 0, 32'h0, 1'b0, 0);
        run_instr(2, 0, 1, 32'h1234_5678, 1'b0, 0);

        // Reset asserted mid-DECODE, checked before any clock edge.
        do_fetch(0);
        do_decode(6'b000010, 6'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 80; n++)
            run_instr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom, 1'($urandom), $urandom_range(0, 4));

        // Halt: parks, ignores all inputs, only reset leaves.
        do_fetch(1);
        do_decode(6'b111111, 6'($urandom));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            randomize_misc();
            imem_valid = 1'b1;
            #1;
            check_common();
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_pcw", {31'd0, pc_write}, 32'd0);
            check("halt_irw", {31'd0, ir_write}, 32'd0);
        end
        #2;
        imem_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("halt_rst");
        @(negedge clk);
        reset = 1'b0;
        run_instr(0, 1, 0, 32'h0000_0100, 1'b0, 0);
        @(negedge clk);
        #1;
        check_common();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle PC sequencer that drives the select side of the PC-source mux and owns the program-counter register.
- Steps an instruction through FETCH/DECODE and then a branch, jump, exec or halt path.
- Generates sel_pc, pc_write and ir_write, and registers the muxed next-PC value.
- Handshakes with instruction memory and with the main control unit; counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
OP_HALT, 6'b111111, opcode that parks the sequencer

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag
next_pc  in  32  output of PC-source mux
imem_valid  in  1  instruction word valid this cycle
op_done  in  1  main control reports EXEC path complete
imem_req  out  1  instruction fetch request
sel_pc  out  2  00 live ALU result, 01 ALUOut register, 10 jump concat
pc_write  out  1  PC load enable (also exported to datapath)
ir_write  out  1  IR load enable
pc  out  32  current program counter
retired  out  32  retired-instruction counter
halted  out  1  sequencer parked in HALT

Behaviour:
- One clock domain: clk. reset is asynchronous and active-high.
- Reset values:
  - state=FETCH, pc=RESET_PC, retired=0, halted=0.
  - sel_pc=00. imem_req=1, because imem_req is decoded from the FETCH state.
  - pc_write=0 and ir_write=0.
- sel_pc, imem_req and halted are Moore outputs decoded from the state. pc_write and ir_write are combinational from state plus inputs.
- sel_pc must never be 2'b11 in any state.
- PC update: pc<=next_pc on the clock edge where pc_write=1; otherwise pc holds.
- FETCH:
  - imem_req=1, sel_pc=00.
  - While imem_valid=0: stay in FETCH, pc_write=0, ir_write=0.
  - On imem_valid=1: ir_write=1, pc_write=1 (PC+4 from ALU), go to DECODE.
- DECODE: one cycle, no writes, sel_pc=00. The datapath computes the branch target into ALUOut this cycle. Next state by opcode:
  - 000010 (J) or 000011 (JAL) -> JUMP.
  - 000100 (BEQ) or 000101 (BNE) -> BRANCH.
  - 000000 with funct 001000 (JR) -> JREG.
  - OP_HALT -> HALT.
  - Anything else -> EXEC.
- JUMP: sel_pc=10, pc_write=1, go to FETCH.
- BRANCH: sel_pc=01. pc_write = (BEQ & alu_zero) | (BNE & ~alu_zero). Go to FETCH regardless of taken/not-taken.
- JREG: sel_pc=00 (ALU passes rs+0), pc_write=1, go to FETCH.
- EXEC:
  - sel_pc=00, pc_write=0.
  - Wait for op_done. If op_done is already high on the first EXEC cycle, the state spends exactly one cycle in EXEC.
  - On op_done go to FETCH.
- HALT: halted=1, no writes, imem_req=0. Only reset leaves HALT.
- retired: increments by 1 (wrapping 32-bit) on every transition into FETCH from JUMP, BRANCH, JREG or EXEC.
- Minimum latencies:
  - Jump/JR/branch: 3 cycles (FETCH, DECODE, action), with imem_valid=1 on the first FETCH cycle.
  - EXEC: at least 3 cycles.
- Reset mid-instruction: state and pc return to reset values immediately (asynchronously). Any partial instruction is discarded and not counted.
- opcode and funct are sampled only in DECODE; IR is stable after ir_write.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state encoding constants: FETCH, DECODE, JUMP, BRANCH, JREG, EXEC, HALT.
  - opcode and funct constants: J, JAL, BEQ, BNE, R-type, JR funct.
  - sel_pc codes SEL_ALU=00, SEL_REG=01, SEL_CONCAT=10.
- Sub-module: none. FSM, PC register and counter stay in one module.

Test Plan:
- Reset mid-instruction: assert reset while in DECODE -> pc=RESET_PC, state=FETCH, retired=0, sel_pc=00 immediately, without waiting for a clock edge.
- Fetch stall: imem_valid low 4 cycles then high, next_pc=0x4 -> pc_write/ir_write pulse once on the 5th cycle; pc=0x4; DECODE follows.
- Jump: opcode=000010, next_pc=0x00400020 in JUMP -> sel_pc=10, pc=0x00400020 after 3 cycles; retired=1.
- Branch: BEQ with alu_zero=1, next_pc=0x40 -> pc=0x40. BNE with alu_zero=1 -> pc_write=0, pc keeps PC+4; both instructions increment retired.
- EXEC handshake: R-type add, op_done held low 3 cycles then high -> 3 EXEC cycles plus 1, then FETCH; sel_pc never 11 throughout.
- Halt: opcode=111111 -> halted=1, imem_req=0; pc and retired frozen for 20 cycles; reset clears halted.
